// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule definitions: word sizes, sigma functions and
// the FSM state encoding used by the schedule roll-back logic.
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int WIN_WORDS = 16;
    localparam int WIN_W     = WORD_W * WIN_WORDS;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [WORD_W-1:0] s0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] s1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_back_step.sv
// One backwards step of the SHA-256 schedule: recovers the word just older than
// the window and returns the window slid one word towards the past.
module sha256_w_back_step
    import sha256_pkg::*;
(
    input  logic [WIN_W-1:0]  win_i,
    output logic [WORD_W-1:0] word_o,
    output logic [WIN_W-1:0]  win_o
);

    logic [WORD_W-1:0] w [WIN_WORDS];

    // w[0] is the oldest word (top of the packed vector), w[15] the newest
    genvar gi;
    generate
        for (gi = 0; gi < WIN_WORDS; gi++) begin : g_unpack
            assign w[gi] = win_i[WIN_W-1-gi*WORD_W -: WORD_W];
        end
    endgenerate

    assign word_o = w[15] - s1(w[13]) - w[8] - s0(w[0]);
    assign win_o  = {word_o, win_i[WIN_W-1:WORD_W]};

endmodule

// File: rtl/sha256_w_unroll.sv
// Rolls a 16-word SHA-256 schedule window back to W[0], one word per beat.
// Define SHA256_W_UNROLL_WINDOW_OUT_EN to expose the recovered message block.
module sha256_w_unroll
    import sha256_pkg::*;
#(
    parameter int TOP_MAX = 63,
    parameter int IDX_W   = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIN_W-1:0]   window_in,
    input  logic [IDX_W-1:0]   top_index_in,
    output logic               w_out_valid,
    input  logic               w_out_ready,
    output logic [WORD_W-1:0]  w_out,
    output logic [IDX_W-1:0]   w_out_index,
    output logic               busy,
    output logic               done,
    output logic               err
`ifdef SHA256_W_UNROLL_WINDOW_OUT_EN
    ,
    output logic [WIN_W-1:0]   window_out,
    output logic               window_out_valid
`endif
);

    localparam logic [IDX_W:0]   TOP_LO_X = (IDX_W+1)'(15);
    localparam logic [IDX_W:0]   TOP_HI_X = (IDX_W+1)'(TOP_MAX);
    localparam logic [IDX_W-1:0] TOP_LO   = IDX_W'(15);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    state_e             state_q, state_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [IDX_W-1:0]   j_q, j_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [WORD_W-1:0]  rec_word;
    logic [WIN_W-1:0]   win_shift;
    logic [IDX_W:0]     top_x;

`ifdef SHA256_W_UNROLL_WINDOW_OUT_EN
    logic               wov_q, wov_d;
`endif

    sha256_w_back_step u_step (
        .win_i  (win_q),
        .word_o (rec_word),
        .win_o  (win_shift)
    );

    // Zero-extended so the upper-bound check stays meaningful when TOP_MAX fills IDX_W
    assign top_x = {1'b0, top_index_in};

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        j_d     = j_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef SHA256_W_UNROLL_WINDOW_OUT_EN
        wov_d   = wov_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    if (top_x < TOP_LO_X || top_x > TOP_HI_X) begin
                        err_d = 1'b1;
                    end else begin
                        win_d = window_in;
                        if (top_index_in == TOP_LO) begin
                            done_d = 1'b1;
`ifdef SHA256_W_UNROLL_WINDOW_OUT_EN
                            wov_d  = 1'b1;
`endif
                        end else begin
                            state_d = RUN;
                            j_d     = top_index_in - TOP_LO;
`ifdef SHA256_W_UNROLL_WINDOW_OUT_EN
                            wov_d   = 1'b0;
`endif
                        end
                    end
                end
            end
            RUN: begin
                if (w_out_ready) begin
                    win_d = win_shift;
                    j_d   = j_q - ONE;
                    // j_q == 1 means the word being accepted is W[0]
                    if (j_q == ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
`ifdef SHA256_W_UNROLL_WINDOW_OUT_EN
                        wov_d   = 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            win_q   <= '0;
            j_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef SHA256_W_UNROLL_WINDOW_OUT_EN
            wov_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            j_q     <= j_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef SHA256_W_UNROLL_WINDOW_OUT_EN
            wov_q   <= wov_d;
`endif
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q == RUN);
    assign w_out_valid = (state_q == RUN);
    assign w_out       = (state_q == RUN) ? rec_word : '0;
    assign w_out_index = (state_q == RUN) ? (j_q - ONE) : '0;
    assign done        = done_q;
    assign err         = err_q;

`ifdef SHA256_W_UNROLL_WINDOW_OUT_EN
    assign window_out       = win_q;
    assign window_out_valid = wov_q;
`endif

endmodule

// File: tb/tb_sha256_w_unroll.sv
// Scoreboard bench for sha256_w_unroll; honours SHA256_W_UNROLL_WINDOW_OUT_EN
// by also checking the recovered block outputs when that macro is defined.
module tb_sha256_w_unroll;

    localparam int IW = 7;

    typedef struct {
        int          idx;
        logic [31:0] w;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_valid = 1'b0;
    logic           start_ready;
    logic [511:0]   window_in = '0;
    logic [IW-1:0]  top_index_in = '0;
    logic           w_out_valid;
    logic           w_out_ready = 1'b0;
    logic [31:0]    w_out;
    logic [IW-1:0]  w_out_index;
    logic           busy;
    logic           done;
    logic           err;
`ifdef SHA256_W_UNROLL_WINDOW_OUT_EN
    logic [511:0]   window_out;
    logic           window_out_valid;
`endif

    int             n_tests = 0;
    int             n_fail = 0;
    beat_t          sb[$];
    logic [31:0]    wm [64];

    always #5 clk = ~clk;

    sha256_w_unroll #(
        .TOP_MAX (63),
        .IDX_W   (IW)
    ) dut (
        .CLK          (clk),
        .RST          (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .window_in    (window_in),
        .top_index_in (top_index_in),
        .w_out_valid  (w_out_valid),
        .w_out_ready  (w_out_ready),
        .w_out        (w_out),
        .w_out_index  (w_out_index),
        .busy         (busy),
        .done         (done),
        .err          (err)
`ifdef SHA256_W_UNROLL_WINDOW_OUT_EN
        ,
        .window_out       (window_out),
        .window_out_valid (window_out_valid)
`endif
    );

    function automatic logic [31:0] ms0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ms1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    task automatic random_block();
        for (int t = 0; t < 16; t++) wm[t] = $urandom();
        for (int t = 16; t < 64; t++)
            wm[t] = ms1(wm[t-2]) + wm[t-7] + ms0(wm[t-15]) + wm[t-16];
    endtask

    function automatic logic [511:0] pack(input int base);
        logic [511:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[511-32*k -: 32] = wm[base+k];
        return v;
    endfunction

    task automatic push_expected(input int top);
        for (int i = top - 16; i >= 0; i--) sb.push_back('{i, wm[i]});
    endtask

    task automatic do_load(input int top, input logic [511:0] win);
        @(negedge clk);
        start_valid  = 1'b1;
        top_index_in = IW'(top);
        window_in    = win;
        @(negedge clk);
        start_valid  = 1'b0;
    endtask

    // Called at the negedge right after a load; consumes the scoreboard
    task automatic drain(input int mode, input bit extra_start);
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int phase = 0;
        int cyc = 0;
        bit hold = 0;
        bit last = 0;
        bit finished = 0;
        logic [31:0]   hw = '0;
        logic [IW-1:0] hi = '0;
        beat_t e;
        while (!finished && cyc < 300) begin
            w_out_ready = (mode == 0) ? 1'b1 : pat[phase % 4];
            phase++;
            start_valid = extra_start;
            if (extra_start) begin
                top_index_in = IW'(20);
                for (int k = 0; k < 16; k++) window_in[32*k +: 32] = $urandom();
            end
            n_tests++;
            if (w_out_valid !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL run_state: valid=%b done=%b busy=%b, required valid=1 done=0 busy=1",
                         w_out_valid, done, busy);
            end
            if (hold) begin
                n_tests++;
                if (w_out !== hw || w_out_index !== hi) begin
                    n_fail++;
                    $display("FAIL hold_stable: idx=%0d w=%08h, required idx=%0d w=%08h",
                             w_out_index, w_out, hi, hw);
                end
            end
            if (w_out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_beat: idx=%0d w=%08h, required none", w_out_index, w_out);
                    last = 1;
                end else begin
                    e = sb.pop_front();
                    n_tests++;
                    $display("[TB] beat idx=%0d w=%08h (expected idx=%0d w=%08h)",
                             w_out_index, w_out, e.idx, e.w);
                    if (w_out_index !== IW'(e.idx) || w_out !== e.w) begin
                        n_fail++;
                        $display("FAIL beat: idx=%0d w=%08h, required idx=%0d w=%08h",
                                 w_out_index, w_out, e.idx, e.w);
                    end
                    last = (sb.size() == 0);
                end
                hold = 0;
            end else begin
                hold = 1;
                hw = w_out;
                hi = w_out_index;
            end
            @(negedge clk);
            cyc++;
            if (last) begin
                start_valid = 1'b0;
                w_out_ready = 1'b0;
                n_tests++;
                if (done !== 1'b1 || w_out_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL end_of_run: done=%b valid=%b busy=%b ready=%b, required 1 0 0 1",
                             done, w_out_valid, busy, start_ready);
                end
                finished = 1;
            end
        end
        start_valid = 1'b0;
        if (!finished) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words left, required 0", sb.size());
        end
    endtask

    task automatic check_block();
`ifdef SHA256_W_UNROLL_WINDOW_OUT_EN
        n_tests++;
        if (window_out_valid !== 1'b1 || window_out !== pack(0)) begin
            n_fail++;
            $display("FAIL window_out: valid=%b top_word=%08h, required valid=1 top_word=%08h",
                     window_out_valid, window_out[511:480], wm[0]);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_valid = 1'b0;
        w_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (w_out_valid !== 1'b0 || w_out !== 32'h0 || w_out_index !== '0 || busy !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0 || start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: valid=%b w=%08h idx=%0d busy=%b done=%b err=%b ready=%b, required 0 0 0 0 0 0 1",
                     w_out_valid, w_out, w_out_index, busy, done, err, start_ready);
        end
`ifdef SHA256_W_UNROLL_WINDOW_OUT_EN
        n_tests++;
        if (window_out_valid !== 1'b0 || window_out !== '0) begin
            n_fail++;
            $display("FAIL reset_window: valid=%b, required 0 with zero window", window_out_valid);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic setup_abc();
        for (int t = 0; t < 64; t++) wm[t] = 32'h0;
        wm[0]  = 32'h61626380;
        wm[15] = 32'h00000018;
        wm[16] = 32'h61626380;
        wm[17] = 32'h000F0000;
    endtask

    task automatic test_abc(input int mode);
        setup_abc();
        sb.push_back('{1, 32'h00000000});
        sb.push_back('{0, 32'h61626380});
        do_load(17, pack(2));
        drain(mode, 1'b0);
        check_block();
    endtask

    task automatic test_full_rollback();
        random_block();
        push_expected(63);
        do_load(63, pack(48));
        drain(0, 1'b0);
        check_block();
    endtask

    task automatic test_start_during_run();
        random_block();
        push_expected(40);
        do_load(40, pack(25));
        drain(0, 1'b1);
        check_block();
    endtask

    task automatic test_trivial();
        random_block();
        do_load(15, pack(0));
        n_tests++;
        if (done !== 1'b1 || w_out_valid !== 1'b0 || err !== 1'b0 || start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL trivial_done: done=%b valid=%b err=%b ready=%b, required 1 0 0 1",
                     done, w_out_valid, err, start_ready);
        end
        check_block();
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || w_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL trivial_after: done=%b valid=%b, required 0 0", done, w_out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        beat_t e;
        random_block();
        push_expected(63);
        do_load(63, pack(48));
        w_out_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            e = sb.pop_front();
            n_tests++;
            $display("[TB] beat idx=%0d w=%08h (expected idx=%0d w=%08h)", w_out_index, w_out, e.idx, e.w);
            if (w_out_valid !== 1'b1 || w_out_index !== IW'(e.idx) || w_out !== e.w) begin
                n_fail++;
                $display("FAIL pre_abort_beat: valid=%b idx=%0d w=%08h, required 1 %0d %08h",
                         w_out_valid, w_out_index, w_out, e.idx, e.w);
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        w_out_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (w_out_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: valid=%b busy=%b ready=%b done=%b, required 0 0 1 0",
                     w_out_valid, busy, start_ready, done);
        end
        rst_n = 1'b1;
        sb.delete();
        test_full_rollback();
    endtask

    task automatic test_err(input int top);
        for (int k = 0; k < 16; k++) window_in[32*k +: 32] = $urandom();
        do_load(top, window_in);
        n_tests++;
        if (err !== 1'b1 || done !== 1'b0 || start_ready !== 1'b1 || w_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_top%0d: err=%b done=%b ready=%b valid=%b, required 1 0 1 0",
                     top, err, done, start_ready, w_out_valid);
        end
        @(negedge clk);
        n_tests++;
        if (err !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sticky_top%0d: err=%b done=%b, required 1 0", top, err, done);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_abc(0);
        test_abc(1);
        test_full_rollback();
        test_start_during_run();
        test_trivial();
        test_reset_mid_run();
        test_err(14);
        test_reset();
        test_err(64);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_w_unroll.md
Name: sha256_w_unroll

Overview:
- Inverse of the SHA-256 message-schedule pipeline stage: given a 16-word schedule window W[j..j+15], walks the recurrence backwards and recovers W[j-1], W[j-2], …, W[0], one word per accepted output beat.
- Sits beside the W-memory pipeline for debug/verification and for midstate reconstruction, where a later schedule window must be rolled back to the original message block.

Parameters:
- TOP_MAX, 63, largest accepted newest-word index (range 15..63).
- IDX_W, 6, width of index fields.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-low reset.
- start_valid  in  1  load request.
- start_ready  out  1  high only in IDLE.
- window_in  in  512  W[j..j+15]; bits [511:480] = W[j] (oldest), bits [31:0] = W[j+15] (newest).
- top_index_in  in  IDX_W  index j+15 of the newest word; legal 15..TOP_MAX.
- w_out_valid  out  1  recovered word available.
- w_out_ready  in  1  consumer accepts.
- w_out  out  32  recovered word.
- w_out_index  out  IDX_W  schedule index of w_out.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when W[0] is accepted, or on a trivial load.
- err  out  1  sticky; set on an illegal top_index_in load; cleared by reset.

Behaviour:
- Reset values (RST=0 at a clock edge): state IDLE, window 0, counters 0. Outputs: w_out_valid 0, w_out 0, w_out_index 0, busy 0, done 0, err 0, start_ready 1.
- Arithmetic is mod 2^32:
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - With oldest index j: W[j-1] = W[j+15] - s1(W[j+13]) - W[j+8] - s0(W[j]).
- IDLE:
  - start_valid & start_ready with top_index_in in 16..TOP_MAX: register window, set j = top_index_in - 15, go to RUN.
  - top_index_in == 15: nothing to recover. Pulse done next cycle, stay IDLE.
  - top_index_in < 15 or > TOP_MAX: set err, stay IDLE, no done.
- RUN:
  - w_out_valid = 1. w_out is the combinational recovery from the registered window; w_out_index = j-1.
  - On w_out_valid & w_out_ready: window <= {W[j-1], W[j..j+14]} (right shift by one word, drops the newest), j <= j-1.
  - If the accepted index was 0: go IDLE and pulse done the same edge (done is high the following cycle).
  - Holding: while w_out_ready = 0, w_out and w_out_index stay stable; valid never drops before acceptance.
- Latency: first word is valid 1 cycle after load acceptance. Throughput is 1 word/cycle with ready held high. A load with newest index t produces exactly t-15 beats.
- start_valid is ignored (no error) while in RUN.
- Reset mid-RUN: abort immediately to reset values; no done.

Optional Feature:
- Macro: SHA256_W_UNROLL_WINDOW_OUT_EN.
- Defined: adds outputs window_out[511:0] and window_out_valid.
  - window_out holds W[0..15] in window_in packing, i.e. the recovered message block.
  - window_out_valid rises with done and stays high until the next load acceptance or reset.
  - On a trivial top=15 load, window_out = window_in.
- Undefined: ports absent; no extra registers.

Decomposition:
- Shared package sha256_pkg:
  - s0/s1 functions.
  - WORD_W = 32, WIN_WORDS = 16.
  - State encoding typedef {IDLE, RUN}.
- One natural sub-module: sha256_w_back_step, combinational; takes the 512-bit window and returns the recovered 32-bit word plus the shifted 512-bit window.
- FSM, counter and handshake stay in the top module.

Test Plan:
- Message "abc": W0 = 0x61626380, W1..W14 = 0, W15 = 0x18, hence W16 = 0x61626380, W17 = 0x000F0000.
  - Load W2..W17, top = 17, ready held 1 → beats (idx1, 0x00000000), (idx0, 0x61626380); done pulses the cycle after the 2nd beat.
- Full rollback: run the forward schedule of a random block to W63; load W48..W63, top = 63 → 48 beats reproduce W47..W0 exactly, back-to-back; with the macro on, window_out equals the original block.
- Backpressure: same as the "abc" case with w_out_ready toggling 1,0,0,1 → w_out/w_out_index held stable during the low cycles; order unchanged; no duplicate beats.
- Boundaries:
  - top = 15 → no beats, done one cycle later.
  - top = 14 → err = 1, no done, start_ready remains 1.
  - top = 64 with TOP_MAX = 63 → err = 1.
- Reset mid-RUN: assert RST=0 after 5 beats of the full rollback → next cycle w_out_valid 0, busy 0, start_ready 1, no done; a fresh load runs correctly.
- start_valid asserted during RUN → ignored; sequence and done identical to the run without it.
